// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Round-robin front end that lets NUM_REQ command sources share a single
// multi-cycle ALU. One command is in flight at a time: it is granted,
// issued to the ALU, waited on under a watchdog, and returned with the
// originating requester ID on a valid/ready response port.
//
// Optional build macro ALU_DIV0_GUARD_EN: when defined, a divide whose
// divisor is zero is answered locally with an error response and never
// reaches the ALU.
module alu_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*10-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  alu_valid,
    output logic [3:0]            alu_data1,
    output logic [3:0]            alu_data2,
    output logic [1:0]            alu_op,
    input  logic [8:0]            alu_result,
    input  logic                  alu_done,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8:0]            rsp_result,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Requester count and last index at the widths they are compared against.
    localparam logic [ID_W:0]   NUM_REQ_W    = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID      = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W-1:0] ID_ONE       = ID_W'(1);
    // The watchdog counts completed WAIT cycles, so the final allowed WAIT
    // cycle is the one where it still reads TIMEOUT_CYCLES-1.
    localparam logic [7:0]      TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] READY_ONE = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_nxt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       op_id;
    logic [7:0]            wdog;

    logic [2*NUM_REQ-1:0]  req_dbl;
    logic [NUM_REQ-1:0]    req_rot;
    logic [ID_W-1:0]       gnt_ofs;
    logic [ID_W:0]         gnt_sum;
    logic [ID_W-1:0]       gnt_id;
    logic                  gnt_any;
    logic [9:0]            gnt_cmd;

    logic                  accept;
    logic                  div0_bypass;
    logic                  wd_expire;

    // Rotate the request vector so rr_ptr sits at bit 0, pick the lowest
    // set bit, then rotate the winner back into an absolute requester ID.
    always_comb begin
        req_dbl = {req_valid, req_valid} >> rr_ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        gnt_any = 1'b0;
        gnt_ofs = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_any = 1'b1;
                gnt_ofs = ID_W'(k);
            end
        end
        gnt_sum = {1'b0, rr_ptr} + {1'b0, gnt_ofs};
        if (gnt_sum >= NUM_REQ_W) begin
            gnt_sum = gnt_sum - NUM_REQ_W;
        end
        gnt_id = gnt_sum[ID_W-1:0];
    end

    // Select the granted requester's command word {op, data2, data1}.
    always_comb begin
        gnt_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                gnt_cmd = req_data[i*10 +: 10];
            end
        end
    end

`ifdef ALU_DIV0_GUARD_EN
    // Divide with a zero divisor is answered locally instead of issued.
    assign div0_bypass = (gnt_cmd[9:8] == 2'd3) && (gnt_cmd[7:4] == 4'd0);
`else
    assign div0_bypass = 1'b0;
`endif

    assign accept    = (state == IDLE) && gnt_any && !reset;
    assign wd_expire = (wdog == TIMEOUT_LAST);
    assign rsp_id    = op_id;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the handshake strobes that depend only on state.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        alu_valid = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any && !reset) begin
                    req_ready = READY_ONE << gnt_id;
                    state_nxt = div0_bypass ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                alu_valid = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (alu_done || wd_expire) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Round-robin pointer moves just past whoever was granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + ID_ONE;
        end
    end

    // Latch the accepted command; these drive the ALU until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_op    <= '0;
            alu_data2 <= '0;
            alu_data1 <= '0;
            op_id     <= '0;
        end else if (accept) begin
            alu_op    <= gnt_cmd[9:8];
            alu_data2 <= gnt_cmd[7:4];
            alu_data1 <= gnt_cmd[3:0];
            op_id     <= gnt_id;
        end
    end

    // Watchdog counts WAIT cycles; cleared once the response is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog <= '0;
        end else if (state == WAIT) begin
            wdog <= wdog + 8'd1;
        end else if ((state == RESP) && rsp_ready) begin
            wdog <= '0;
        end
    end

    // Capture the response payload; it holds until the next transaction ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else if (accept && div0_bypass) begin
            rsp_result <= 9'h1FF;
            rsp_err    <= 1'b1;
        end else if ((state == WAIT) && alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
        end else if ((state == WAIT) && wd_expire) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
        end
    end

endmodule
